adc_bcd_conv: RTL and testbench

- Sits directly downstream of the SPI ADC reader.
- Consumes each 12-bit sample plus its one-cycle valid strobe.
- Converts the sample to four BCD digits using a sequential shift-add-3 (double-dabble) state machine.
- Feeds the 7-segment controller's ones/tens/hundreds/thousands inputs, so the display shows the live ADC code instead of a free-running count.

---
 rtl/adc_bcd_conv.sv | 189 ++++++++++++++++++
 tb/tb_adc_bcd_conv.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_bcd_conv.sv
// adc_bcd_conv: converts each accepted 12-bit ADC sample into four BCD digits
// with a sequential shift-add-3 (double-dabble) engine, one shift per clock.
// A sample is accepted when the divider selects it and the engine is idle.
// The digit outputs hold their value until the next conversion completes.
// Optional build macro ADC_BCD_AVG_EN: each group of four valid samples is
// averaged (truncating mean) and only the average becomes a candidate.
module adc_bcd_conv #(
  parameter int unsigned UPDATE_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] i_data,
  input  logic        i_data_valid,
  output logic [3:0]  o_ones,
  output logic [3:0]  o_tens,
  output logic [3:0]  o_hundreds,
  output logic [3:0]  o_thousands,
  output logic        o_done,
  output logic        o_busy,
  output logic        o_drop
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(UPDATE_DIV - 1);

  // One double-dabble step: correct every nibble >= 5, then shift {bcd,bin} left.
  function automatic logic [27:0] dabble_step(input logic [15:0] bcd,
                                              input logic [11:0] bin);
    logic [15:0] adj;
    for (int n = 0; n < 4; n++) begin
      adj[4*n +: 4] = (bcd[4*n +: 4] >= 4'd5) ? bcd[4*n +: 4] + 4'd3
                                               : bcd[4*n +: 4];
    end
    return 28'({adj, bin} << 1);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  sh_cnt_q;
  logic [11:0] bin_sr_q;
  logic [15:0] bcd_sr_q;
  logic [15:0] digits_q;
  logic        done_q;
  logic        drop_q;
  logic [7:0]  div_cnt_q, div_cnt_d;

  logic        cand_vld;
  logic [11:0] cand_data;
  logic        launch;
  logic        ld_en, sh_en, cmt_en, drop_d, busy;

`ifdef ADC_BCD_AVG_EN
  logic [13:0] acc_q, acc_d, acc_sum;
  logic [1:0]  smp_cnt_q, smp_cnt_d;

  // Accumulate four valid samples; the fourth one emits the truncated mean.
  always_comb begin
    acc_sum   = acc_q + {2'b00, i_data};
    acc_d     = acc_q;
    smp_cnt_d = smp_cnt_q;
    cand_vld  = 1'b0;
    if (i_data_valid) begin
      if (smp_cnt_q == 2'd3) begin
        acc_d     = '0;
        smp_cnt_d = '0;
        cand_vld  = 1'b1;
      end else begin
        acc_d     = acc_sum;
        smp_cnt_d = smp_cnt_q + 2'd1;
      end
    end
    cand_data = 12'(acc_sum >> 2);
  end

  // Averaging accumulator and sample counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      smp_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      smp_cnt_q <= smp_cnt_d;
    end
  end
`else
  // Every raw valid sample is a candidate.
  always_comb begin
    cand_vld  = i_data_valid;
    cand_data = i_data;
  end
`endif

  // Divider counts all candidates, dropped ones included; the last slot launches.
  always_comb begin
    div_cnt_d = div_cnt_q;
    launch    = cand_vld && (div_cnt_q == DIV_LAST);
    if (cand_vld) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? 8'd0 : div_cnt_q + 8'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: twelve shifts (count 0..11), then one commit cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = SHIFT;
      SHIFT:   if (sh_cnt_q == 4'd11) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: datapath enables, busy flag, and drop request.
  always_comb begin
    ld_en  = 1'b0;
    sh_en  = 1'b0;
    cmt_en = 1'b0;
    drop_d = 1'b0;
    busy   = 1'b0;
    case (state_q)
      IDLE: begin
        ld_en = launch;
      end
      SHIFT: begin
        sh_en  = 1'b1;
        busy   = 1'b1;
        drop_d = launch;
      end
      DONE: begin
        cmt_en = 1'b1;
        busy   = 1'b1;
        drop_d = launch;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Divider, shift registers, digit holding register and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      sh_cnt_q  <= '0;
      bin_sr_q  <= '0;
      bcd_sr_q  <= '0;
      digits_q  <= '0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      if (ld_en) begin
        bin_sr_q <= cand_data;
        bcd_sr_q <= '0;
        sh_cnt_q <= '0;
      end else if (sh_en) begin
        {bcd_sr_q, bin_sr_q} <= dabble_step(bcd_sr_q, bin_sr_q);
        sh_cnt_q             <= sh_cnt_q + 4'd1;
      end
      if (cmt_en) begin
        digits_q <= bcd_sr_q;
      end
      done_q <= cmt_en;
      drop_q <= drop_d;
    end
  end

  assign o_thousands = digits_q[15:12];
  assign o_hundreds  = digits_q[11:8];
  assign o_tens      = digits_q[7:4];
  assign o_ones      = digits_q[3:0];
  assign o_done      = done_q;
  assign o_drop      = drop_q;
  assign o_busy      = busy;

endmodule

// File: tb/tb_adc_bcd_conv.sv
// Testbench for adc_bcd_conv: one instance with UPDATE_DIV=1, one with
// UPDATE_DIV=3. Expected digits come from decimal arithmetic on the sample.
// Builds with or without ADC_BCD_AVG_EN; in averaged builds each logical
// sample is sent as four identical valid pulses so the mean equals the value.
module tb_adc_bcd_conv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] d0, d3;
  logic        v0, v3;
  logic [3:0]  on0, te0, hu0, th0, on3, te3, hu3, th3;
  logic        done0, busy0, drop0, done3, busy3, drop3;
  logic [15:0] dig0, dig3;

  int checks = 0;
  int errors = 0;
  int done0_cnt = 0, drop0_cnt = 0, done3_cnt = 0, drop3_cnt = 0;
  int cnt3 = 0;
  int last3 = 0;

  always #5 clk = ~clk;

  assign dig0 = {th0, hu0, te0, on0};
  assign dig3 = {th3, hu3, te3, on3};

  adc_bcd_conv #(.UPDATE_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(d0), .i_data_valid(v0),
    .o_ones(on0), .o_tens(te0), .o_hundreds(hu0), .o_thousands(th0),
    .o_done(done0), .o_busy(busy0), .o_drop(drop0)
  );

  adc_bcd_conv #(.UPDATE_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_data(d3), .i_data_valid(v3),
    .o_ones(on3), .o_tens(te3), .o_hundreds(hu3), .o_thousands(th3),
    .o_done(done3), .o_busy(busy3), .o_drop(drop3)
  );

  always @(negedge clk) begin
    if (done0 === 1'b1) done0_cnt++;
    if (drop0 === 1'b1) drop0_cnt++;
    if (done3 === 1'b1) done3_cnt++;
    if (drop3 === 1'b1) drop3_cnt++;
  end

  function automatic logic [15:0] ref_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Called at a negedge; the valid pulse is sampled at the following posedge.
  task automatic send_raw(input int sel, input int v);
    if (sel == 0) begin d0 = 12'(v); v0 = 1'b1; end
    else          begin d3 = 12'(v); v3 = 1'b1; end
    @(negedge clk);
    v0 = 1'b0;
    v3 = 1'b0;
  endtask

  task automatic send(input int sel, input int v);
`ifdef ADC_BCD_AVG_EN
    repeat (4) send_raw(sel, v);
`else
    send_raw(sel, v);
`endif
  endtask

  // Starts at the negedge right after the candidate edge; bounded by 40 cycles.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    while (done0 !== 1'b1 && lat < 40) begin
      if (busy0 === 1'b1) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v0 = 1'b0; v3 = 1'b0; d0 = '0; d3 = '0;
    repeat (6) begin
      @(negedge clk);
      v0 = ~v0; v3 = ~v3;
      d0 = 12'($urandom); d3 = 12'($urandom);
    end
    checks++; if (dig0 !== 16'h0) begin errors++; $display("FAIL reset_digits got %h expected 0000", dig0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done0); end
    checks++; if (drop0 !== 1'b0) begin errors++; $display("FAIL reset_drop got %b expected 0", drop0); end
    @(negedge clk);
    v0 = 1'b0; v3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (dig0 !== 16'h0) begin errors++; $display("FAIL post_reset_digits got %h expected 0000", dig0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b expected 0", busy0); end
    checks++; if (dig3 !== 16'h0) begin errors++; $display("FAIL post_reset_digits3 got %h expected 0000", dig3); end
    cnt3 = 0;
    last3 = 0;
  endtask

  task automatic test_convert(input int v);
    int lat, bc, dc;
    dc = done0_cnt;
    send(0, v);
    wait_done(lat, bc);
    checks++; if (lat != 13) begin errors++; $display("FAIL latency(%0d) got %0d expected 13", v, lat); end
    checks++; if (bc != 13) begin errors++; $display("FAIL busy_cycles(%0d) got %0d expected 13", v, bc); end
    checks++; if (dig0 !== ref_bcd(v)) begin errors++; $display("FAIL digits(%0d) got %h expected %h", v, dig0, ref_bcd(v)); end
    @(negedge clk);
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL done_width(%0d) got %b expected 0", v, done0); end
    checks++; if (done0_cnt - dc != 1) begin errors++; $display("FAIL done_count(%0d) got %0d expected 1", v, done0_cnt - dc); end
  endtask

  task automatic test_drop();
    int dc, pc;
    dc = done0_cnt;
    pc = drop0_cnt;
    send(0, 1000);
    repeat (4) @(negedge clk);
    send(0, 2000);
    checks++; if (drop0 !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b expected 1", drop0); end
    repeat (25) @(negedge clk);
    checks++; if (drop0_cnt - pc != 1) begin errors++; $display("FAIL drop_count got %0d expected 1", drop0_cnt - pc); end
    checks++; if (done0_cnt - dc != 1) begin errors++; $display("FAIL drop_done_count got %0d expected 1", done0_cnt - dc); end
    checks++; if (dig0 !== ref_bcd(1000)) begin errors++; $display("FAIL drop_digits got %h expected %h", dig0, ref_bcd(1000)); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, dc, pc;
    dc = done0_cnt;
    pc = drop0_cnt;
    send(0, 7);
    wait_done(lat, bc);
    checks++; if (dig0 !== ref_bcd(7)) begin errors++; $display("FAIL b2b_first got %h expected %h", dig0, ref_bcd(7)); end
    send(0, 8);
    wait_done(lat, bc);
    checks++; if (lat != 13) begin errors++; $display("FAIL b2b_latency got %0d expected 13", lat); end
    checks++; if (dig0 !== ref_bcd(8)) begin errors++; $display("FAIL b2b_second got %h expected %h", dig0, ref_bcd(8)); end
    @(negedge clk);
    checks++; if (done0_cnt - dc != 2) begin errors++; $display("FAIL b2b_done_count got %0d expected 2", done0_cnt - dc); end
    checks++; if (drop0_cnt - pc != 0) begin errors++; $display("FAIL b2b_drop_count got %0d expected 0", drop0_cnt - pc); end
  endtask

  task automatic test_update_div();
    int dc, pc;
    dc = done3_cnt;
    pc = drop3_cnt;
    send(1, 100);
    repeat (19) @(negedge clk);
    send(1, 200);
    repeat (19) @(negedge clk);
    send(1, 300);
    repeat (20) @(negedge clk);
    cnt3 = (cnt3 + 3) % 3;
    last3 = 300;
    checks++; if (done3_cnt - dc != 1) begin errors++; $display("FAIL div3_done_count got %0d expected 1", done3_cnt - dc); end
    checks++; if (drop3_cnt - pc != 0) begin errors++; $display("FAIL div3_drop_count got %0d expected 0", drop3_cnt - pc); end
    checks++; if (dig3 !== ref_bcd(300)) begin errors++; $display("FAIL div3_digits got %h expected %h", dig3, ref_bcd(300)); end
  endtask

  task automatic test_div_random();
    int v, dc, exp_done;
    for (int i = 0; i < 9; i++) begin
      v = int'($urandom_range(0, 4095));
      dc = done3_cnt;
      exp_done = (cnt3 == 2) ? 1 : 0;
      if (exp_done == 1) last3 = v;
      cnt3 = (cnt3 + 1) % 3;
      send(1, v);
      repeat (18) @(negedge clk);
      checks++; if (done3_cnt - dc != exp_done) begin errors++; $display("FAIL div3_rand_done(%0d) got %0d expected %0d", v, done3_cnt - dc, exp_done); end
      checks++; if (dig3 !== ref_bcd(last3)) begin errors++; $display("FAIL div3_rand_digits(%0d) got %h expected %h", v, dig3, ref_bcd(last3)); end
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    dc = done0_cnt;
    send(0, 4095);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dig0 !== 16'h0) begin errors++; $display("FAIL midreset_digits got %h expected 0000", dig0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b expected 0", busy0); end
    checks++; if (dig3 !== 16'h0) begin errors++; $display("FAIL midreset_digits3 got %h expected 0000", dig3); end
    @(negedge clk);
    rst_n = 1'b1;
    cnt3 = 0;
    last3 = 0;
    repeat (20) @(negedge clk);
    checks++; if (done0_cnt - dc != 0) begin errors++; $display("FAIL midreset_done_count got %0d expected 0", done0_cnt - dc); end
    checks++; if (dig0 !== 16'h0) begin errors++; $display("FAIL midreset_hold got %h expected 0000", dig0); end
    test_convert(99);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      test_convert(int'($urandom_range(0, 4095)));
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end
  endtask

`ifdef ADC_BCD_AVG_EN
  task automatic test_avg();
    int lat, bc, dc, sum;
    int s [4];
    dc = done0_cnt;
    send_raw(0, 100);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL avg_busy1 got %b expected 0", busy0); end
    send_raw(0, 101);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL avg_busy2 got %b expected 0", busy0); end
    send_raw(0, 102);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL avg_busy3 got %b expected 0", busy0); end
    send_raw(0, 103);
    wait_done(lat, bc);
    checks++; if (lat != 13) begin errors++; $display("FAIL avg_latency got %0d expected 13", lat); end
    checks++; if (dig0 !== ref_bcd(101)) begin errors++; $display("FAIL avg_digits got %h expected %h", dig0, ref_bcd(101)); end
    @(negedge clk);
    checks++; if (done0_cnt - dc != 1) begin errors++; $display("FAIL avg_done_count got %0d expected 1", done0_cnt - dc); end
    for (int r = 0; r < 4; r++) begin
      sum = 0;
      for (int k = 0; k < 4; k++) begin
        s[k] = int'($urandom_range(0, 4095));
        sum += s[k];
      end
      for (int k = 0; k < 4; k++) send_raw(0, s[k]);
      wait_done(lat, bc);
      checks++; if (dig0 !== ref_bcd(sum / 4)) begin errors++; $display("FAIL avg_rand_digits got %h expected %h", dig0, ref_bcd(sum / 4)); end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_convert(4095);
    test_convert(0);
    test_convert(1234);
    test_drop();
    test_back_to_back();
    test_update_div();
    test_div_random();
    test_reset_mid();
    test_random();
`ifdef ADC_BCD_AVG_EN
    test_avg();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
